// File: rtl/display_pkg.sv
// display_pkg: shared BCD display-link constants, receiver state encoding and digit legality check.
package display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;
  // Word is zero-extended to 64 bits so every digit count up to 16 shares one signature.
  function automatic logic bcd_is_legal(input logic [63:0] word, input int digits = NUM_DIGITS);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (i < digits && word[4*i +: 4] > BCD_MAX_DIGIT) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bit_sync.sv
// bit_sync: two-flop synchronizer with asynchronous active-low reset to 0.
module bit_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) s <= 2'b00;
    else s <= {s[0], d};
  assign q = s[1];
endmodule

// File: rtl/display_rx.sv
// display_rx: serial BCD display-link receiver; deserialises, checks framing/digits, strobes the word.
// Define DISPLAY_RX_SYNC_EN to pass ser_data/ser_frame through two-flop synchronizers (+2 cycles latency).
module display_rx #(
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS,
  localparam int W = 4 * NUM_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_data,
  input  logic         ser_frame,
  output logic [W-1:0] bcd_out,
  output logic         bcd_valid,
  output logic         frame_err,
  output logic         digit_err,
  output logic         busy
);
  import display_pkg::*;
  localparam int CW = $clog2(W + 1);
  logic data, frame;
`ifdef DISPLAY_RX_SYNC_EN
  bit_sync u_sync_data  (.clk(clk), .rst(rst), .d(ser_data),  .q(data));
  bit_sync u_sync_frame (.clk(clk), .rst(rst), .d(ser_frame), .q(frame));
`else
  assign data  = ser_data;
  assign frame = ser_frame;
`endif
  state_t state, state_n;
  logic [W-1:0] shreg, shreg_n, out_n;
  logic [CW-1:0] cnt, cnt_n;
  logic valid_n, ferr_n, derr_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      frame_err <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      bcd_out   <= out_n;
      bcd_valid <= valid_n;
      frame_err <= ferr_n;
      digit_err <= derr_n;
    end
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    out_n   = bcd_out;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    derr_n  = 1'b0;
    unique case (state)
      IDLE:
        if (frame) begin
          shreg_n = {shreg[W-2:0], data};
          cnt_n   = CW'(1);
          state_n = SHIFT;
        end
      SHIFT:
        if (frame) begin
          if (cnt == CW'(W)) state_n = OVERRUN;
          else begin
            shreg_n = {shreg[W-2:0], data};
            cnt_n   = cnt + CW'(1);
          end
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
          if (cnt != CW'(W)) ferr_n = 1'b1;
          else if (!bcd_is_legal(64'(shreg), NUM_DIGITS)) derr_n = 1'b1;
          else begin
            out_n   = shreg;
            valid_n = 1'b1;
          end
        end
      OVERRUN:
        if (!frame) begin
          ferr_n  = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_display_rx.sv
// tb_display_rx: table vectors, hand-written corner sequences and random frames checked against a bit-queue model.
module tb_display_rx;
`ifdef DISPLAY_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 0, rst = 0, ser_data = 0, ser_frame = 0;
  logic [15:0] bcd_out;
  logic bcd_valid, frame_err, digit_err, busy;
  display_rx dut (.clk(clk), .rst(rst), .ser_data(ser_data), .ser_frame(ser_frame),
    .bcd_out(bcd_out), .bcd_valid(bcd_valid), .frame_err(frame_err), .digit_err(digit_err), .busy(busy));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic mq[$];
  logic [15:0] m_out;
  logic [1:0] pipe[$];
  int vt[$];
  logic [15:0] vo[$];
  typedef struct {
    logic [15:0] word;
    int nbits;
    logic ev, ef, ed;
    logic [15:0] eo;
  } vec_t;
  vec_t tbl[10];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
  endtask
  // Model: collect the bits of a frame, judge the whole frame once it closes.
  task automatic model(input logic f, input logic d, output logic [19:0] e);
    logic v, fe, de, bad;
    logic [15:0] w;
    v = 0; fe = 0; de = 0;
    if (f) mq.push_back(d);
    else if (mq.size() > 0) begin
      if (mq.size() != 16) fe = 1;
      else begin
        w = 0;
        foreach (mq[i]) w = {w[14:0], mq[i]};
        bad = 0;
        for (int k = 0; k < 4; k++) if (((w >> (4 * k)) & 16'hF) > 9) bad = 1;
        if (bad) de = 1;
        else begin v = 1; m_out = w; end
      end
      mq.delete();
    end
    e = {m_out, v, fe, de, f};
  endtask
  task automatic model_reset();
    mq.delete();
    m_out = 0;
    pipe.delete();
    repeat (LAT) pipe.push_back(2'b00);
  endtask
  task automatic step(input logic f, input logic d);
    logic [19:0] e;
    logic [1:0] pd;
    @(negedge clk);
    ser_frame = f;
    ser_data = d;
    @(posedge clk);
    #1;
    cyc++;
    pipe.push_back({f, d});
    pd = pipe.pop_front();
    model(pd[1], pd[0], e);
    check("model", {12'h0, bcd_out, bcd_valid, frame_err, digit_err, busy}, {12'h0, e});
    if (bcd_valid) begin vt.push_back(cyc); vo.push_back(bcd_out); end
  endtask
  task automatic send(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, i < 16 ? w[15-i] : 1'b0);
  endtask
  initial begin
    logic [15:0] w;
    int n, c1, c2;
    tbl[0] = '{16'h1234, 16, 1, 0, 0, 16'h1234};
    tbl[1] = '{16'h1234, 15, 0, 1, 0, 16'h1234};
    tbl[2] = '{16'h9876, 18, 0, 1, 0, 16'h1234};
    tbl[3] = '{16'h12A4, 16, 0, 0, 1, 16'h1234};
    tbl[4] = '{16'h0999, 16, 1, 0, 0, 16'h0999};
    tbl[5] = '{16'h9999, 16, 1, 0, 0, 16'h9999};
    tbl[6] = '{16'h0000, 16, 1, 0, 0, 16'h0000};
    tbl[7] = '{16'hF000, 16, 0, 0, 1, 16'h0000};
    tbl[8] = '{16'h8000, 1, 0, 1, 0, 16'h0000};
    tbl[9] = '{16'h4321, 17, 0, 1, 0, 16'h0000};
    model_reset();
    #12;
    check("reset_outputs", {11'h0, bcd_out, bcd_valid, frame_err, digit_err, busy}, 0);
    @(negedge clk);
    rst = 1;
    repeat (3) step(0, 0);
    foreach (tbl[t]) begin
      send(tbl[t].word, tbl[t].nbits);
      for (int g = 0; g < LAT + 2; g++) begin
        step(0, 0);
        if (g == LAT)
          check($sformatf("vec%0d", t), {13'h0, bcd_out, bcd_valid, frame_err, digit_err},
                {13'h0, tbl[t].eo, tbl[t].ev, tbl[t].ef, tbl[t].ed});
        if (g == LAT + 1) check($sformatf("vec%0d_pulse_end", t), {bcd_valid, frame_err, digit_err}, 0);
      end
    end
    // Asynchronous reset in the middle of a frame, then a clean frame.
    send(16'h5555, 8);
    #2 rst = 0;
    #1 check("async_reset", {11'h0, bcd_out, bcd_valid, frame_err, digit_err, busy}, 0);
    model_reset();
    @(negedge clk);
    ser_frame = 0;
    rst = 1;
    send(16'h4321, 16);
    for (int g = 0; g < LAT + 2; g++) begin
      step(0, 0);
      if (g == LAT) check("after_reset_frame", {bcd_valid, bcd_out}, {1'b1, 16'h4321});
    end
    // Back-to-back frames separated by one low cycle.
    vt.delete();
    vo.delete();
    send(16'h0001, 16);
    step(0, 0);
    c1 = cyc;
    send(16'h0002, 16);
    step(0, 0);
    c2 = cyc;
    repeat (LAT + 2) step(0, 0);
    check("b2b_count", vt.size(), 2);
    if (vt.size() == 2) begin
      check("b2b_t1", vt[0], c1 + LAT);
      check("b2b_t2", vt[1], c2 + LAT);
      check("b2b_v1", vo[0], 16'h0001);
      check("b2b_v2", vo[1], 16'h0002);
    end
    // Random frames: mostly legal lengths/digits, varied gaps including single-cycle.
    for (int r = 0; r < 300; r++) begin
      for (int k = 0; k < 4; k++)
        w[4*k +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      case ($urandom_range(0, 7))
        0: n = 15;
        1: n = 17;
        2: n = $urandom_range(1, 20);
        default: n = 16;
      endcase
      for (int i = 0; i < n; i++) step(1'b1, i < 16 ? w[15-i] : 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) step(0, 0);
    end
    repeat (LAT + 2) step(0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/display_rx.md
Name: display_rx

Overview:
- Receiving end of the serial BCD display link driven by `display_out`.
- Deserialises the frame-gated bit stream (`ser_data` qualified by `ser_frame`) back into a parallel packed-BCD word.
- Checks framing and digit legality, then presents the word with a one-cycle valid strobe.
- Uses: loopback self-check of the display path on the calculator FPGA, and the display-board side of the link.

Parameters:
- NUM_DIGITS, 4, number of BCD digits per frame; frame length BCD_W = 4*NUM_DIGITS bits (16 by default).

Ports:
- clk  input  1  system clock; the same LF oscillator clock that clocks the transmitter.
- rst  input  1  asynchronous, active-low reset.
- ser_data  input  1  serial data, MSB first; sampled on rising clk.
- ser_frame  input  1  high for exactly the bits of one frame (transmitter `sending_data`).
- bcd_out  output  BCD_W  last good frame; digit 0 is in bits [3:0].
- bcd_valid  output  1  one-cycle pulse when bcd_out updates.
- frame_err  output  1  one-cycle pulse: bit count of a frame was not BCD_W.
- digit_err  output  1  one-cycle pulse: correct length, but some nibble > 9.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, shift register=0, bit count=0.
  - bcd_out=0, bcd_valid=0, frame_err=0, digit_err=0, busy=0.
  - Reset mid-frame discards the partial frame.
- Bit sampling: one bit per clk cycle in which ser_frame=1. There is no oversampling.
- Shift rule: shreg <= {shreg[BCD_W-2:0], ser_data}. The first bit received ends up in bcd_out[BCD_W-1].
- Counter: width $clog2(BCD_W+1).
- FSM states:
  - IDLE:
    - ser_frame=1 → shift in bit, cnt=1, go to SHIFT.
    - Otherwise stay.
  - SHIFT, while ser_frame=1:
    - cnt<BCD_W → shift, cnt+1.
    - cnt==BCD_W → go to OVERRUN; no shift.
  - SHIFT, when ser_frame=0, evaluate the frame:
    - cnt!=BCD_W → frame_err pulse.
    - cnt==BCD_W and any nibble>9 → digit_err pulse.
    - Otherwise → bcd_out<=shreg and bcd_valid pulse.
    - In all cases go to IDLE and clear cnt.
  - OVERRUN: ignore data while ser_frame=1. On ser_frame=0 → frame_err pulse, go to IDLE.
- Latency: the pulse and any bcd_out update are registered. Both appear on the cycle after the first cycle in which ser_frame is sampled low.
- Error handling: bcd_out holds its previous value on any error.
- Pulse exclusivity: at most one of bcd_valid, frame_err and digit_err is high in any cycle.
- Back-to-back frames: a single low cycle of ser_frame is enough to separate two frames.
  - If ser_frame is high again in the cycle that evaluates the previous frame, that cycle counts as the first bit of the next frame.
  - In that case the FSM goes from evaluation directly to SHIFT with cnt=1.
- Zero-length frame: ser_frame never high → no event, no pulses.
- busy: 1 in SHIFT and OVERRUN, 0 in IDLE.

Optional Feature:
- Macro: DISPLAY_RX_SYNC_EN.
- Defined:
  - ser_data and ser_frame each pass through a two-flop synchronizer before the FSM.
  - All latencies increase by 2 cycles.
  - Synchronizer flops reset to 0.
  - Use this build when the link comes from a different clock domain or from an off-board source.
- Undefined: inputs feed the FSM directly; latency is as stated above.

Decomposition:
- Shared package `display_pkg`:
  - NUM_DIGITS default (4), BCD_W, BCD_MAX_DIGIT (4'd9).
  - State enum {IDLE, SHIFT, OVERRUN}.
  - Function `bcd_is_legal(word)`, shared with the ALU and multiplexor checks.
- Sub-module `bit_sync`: 2-flop synchronizer with async active-low reset; instantiated twice under DISPLAY_RX_SYNC_EN.

Test Plan:
- Legal frame: send 0x1234 as 16 frame bits, then drop ser_frame.
  - Next cycle: bcd_out=0x1234 and bcd_valid=1 for exactly one cycle.
  - frame_err=0 and digit_err=0.
- Short frame: send 15 bits after a good 0x1234.
  - frame_err pulses once; bcd_out stays 0x1234; bcd_valid=0.
- Overrun: hold ser_frame high for 17 bits of 0x9876 plus one extra bit.
  - busy stays high; frame_err pulses once after ser_frame falls; bcd_out is unchanged.
- Illegal digit: send 0x12A4.
  - digit_err pulses once; bcd_out keeps its prior value.
  - A following frame of 0x0999 yields bcd_valid with bcd_out=0x0999.
- Reset mid-frame: assert rst after 8 bits of 0x5555.
  - All outputs are 0 immediately (asynchronously).
  - After release, a full 0x4321 frame is received correctly.
- Back-to-back: send frames 0x0001 and 0x0002 separated by one low cycle of ser_frame.
  - Two bcd_valid pulses, each one cycle after its frame, with bcd_out=0x0001 then 0x0002.
  - Repeat with DISPLAY_RX_SYNC_EN defined and confirm each pulse arrives 2 cycles later.
